gelato_ram_responder: RTL

- Responder end of the instruction-fetch RAM protocol: accepts fetch read requests and returns tagged instruction words, in order, after a fixed pipeline latency.
- Holds a word-addressed instruction store that the host preloads through a load port.
- Sits between the fetch unit (initiator) and the instruction memory; in simulation and FPGA builds it acts as the RAM model/controller.

---
 rtl/gelato_ram_pkg.sv | 23 ++
 rtl/gelato_ram_resp_fifo.sv | 60 ++++++
 rtl/gelato_ram_responder.sv | 111 +++++++++++
 3 files changed

// File: rtl/gelato_ram_pkg.sv
// Shared types for the instruction-fetch RAM responder: address/data/tag widths
// and the response record carried through the read pipeline and response FIFO.
package gelato_ram_pkg;

    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int MEM_DEPTH_DEF   = 1024;
    localparam int TAG_W           = 5;
    localparam int LATENCY_DEF     = 2;
    localparam int RESP_DEPTH_DEF  = 4;

    typedef logic [ADDR_W-1:0]                  addr_t;
    typedef logic [DATA_W-1:0]                  data_t;
    typedef logic [TAG_W-1:0]                   tag_t;
    typedef logic [$clog2(MEM_DEPTH_DEF)-1:0]   mem_idx_t;

    typedef struct packed {
        data_t data;
        tag_t  tag;
        logic  err;
    } ram_resp_t;

endpackage

// File: rtl/gelato_ram_resp_fifo.sv
// Response FIFO: head visible combinationally, push/pop take effect at the clock edge.
// No full stall path: the upstream credit count keeps pushes within DEPTH.
module gelato_ram_resp_fifo
    import gelato_ram_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  ram_resp_t        push_dat,
    input  logic             pop,
    output ram_resp_t        head_dat,
    output logic [CNT_W-1:0] count,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ram_resp_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Push into a full FIFO only coincides with a pop of the same slot, whose head is read before the edge.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = cnt_q;
    assign empty    = (cnt_q == '0);

endmodule

// File: rtl/gelato_ram_responder.sv
// Instruction-fetch RAM responder: in-order tagged reads, LATENCY cycles accept-to-response.
// Requests are credit-limited to RESP_DEPTH outstanding; rdy=0 freezes everything.
module gelato_ram_responder
    import gelato_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter int LATENCY    = LATENCY_DEF,
    parameter int RESP_DEPTH = RESP_DEPTH_DEF,
    parameter int TAG_WIDTH  = TAG_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         load_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0]        load_data,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [TAG_WIDTH-1:0]         req_tag,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [DATA_WIDTH-1:0]        resp_data,
    output logic [TAG_WIDTH-1:0]         resp_tag,
    output logic                         resp_err
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(RESP_DEPTH) + 1;
    localparam int PQ    = (LATENCY > 1) ? LATENCY - 1 : 1;

    typedef struct packed {
        logic      vld;
        ram_resp_t r;
    } stage_t;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    stage_t                stg [LATENCY];
    stage_t                pipe_d [PQ];
    stage_t                pipe_q [PQ];
    logic [CNT_W-1:0]      inflight_d, inflight_q, fifo_cnt;
    logic                  accept, push, pop, fifo_empty, addr_err;
    logic [IDX_W-1:0]      idx;
    ram_resp_t             head;

    always_comb begin
        idx       = req_addr[2 +: IDX_W];
        addr_err  = (req_addr[1:0] != 2'b00) || (|req_addr[ADDR_WIDTH-1:2+IDX_W]);
        req_ready = rdy && !rst && !load_en && ((inflight_q + fifo_cnt) < CNT_W'(RESP_DEPTH));
        accept    = req_valid && req_ready;
    end

    // Stage 0 is the accept cycle itself; the last stage feeds the FIFO push.
    always_comb begin
        stg[0].vld    = accept;
        stg[0].r.data = addr_err ? '0 : mem_q[idx];
        stg[0].r.tag  = req_tag;
        stg[0].r.err  = addr_err;
        for (int i = 1; i < LATENCY; i++) begin
            stg[i] = pipe_q[i-1];
        end
        pipe_d = pipe_q;
        if (rdy) begin
            for (int i = 0; i < PQ; i++) begin
                pipe_d[i] = stg[i];
            end
        end
        push       = rdy && stg[LATENCY-1].vld;
        pop        = resp_valid && resp_ready && rdy;
        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            for (int i = 0; i < PQ; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            inflight_q <= inflight_d;
            pipe_q     <= pipe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_en && rdy) begin
            mem_q[load_addr] <= load_data;
        end
    end

    gelato_ram_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (stg[LATENCY-1].r),
        .pop      (pop),
        .head_dat (head),
        .count    (fifo_cnt),
        .empty    (fifo_empty)
    );

    assign resp_valid = !fifo_empty && !rst;
    assign resp_data  = resp_valid ? head.data : '0;
    assign resp_tag   = resp_valid ? head.tag  : '0;
    assign resp_err   = resp_valid ? head.err  : 1'b0;

endmodule
